// File: rtl/grey_step_sequencer_pkg.sv
// Shared definitions for the Gray step sequencer: FSM encoding and code helpers.
package grey_step_sequencer_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } seq_state_t;

    // Binary to Gray on a 32-bit container; callers truncate to their width,
    // which is exact because the upper bits of a zero-extended input stay 0.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Number of set bits, used to check that a step flipped exactly one bit.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/grey_step_sequencer_cnt.sv
// Binary counter with enable and synchronous clear, exposing a registered Gray code.
module gray_cnt_en
    import grey_step_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    // Next binary value: clear wins over enable, natural wrap at the top.
    always_comb begin
        b_next = b_reg;
        if (clr) begin
            b_next = '0;
        end else if (en) begin
            b_next = b_reg + WIDTH'(1);
        end
        q_next = WIDTH'(bin2gray(32'(b_next)));
    end

    // Binary state and Gray output register, updated together so q never lags b.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_reg <= '0;
            q_reg <= '0;
        end else begin
            b_reg <= b_next;
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/grey_step_sequencer.sv
// Run controller for the Gray counter: counted runs with hold, abort, clear,
// busy/done status and a sticky single-bit-step checker on q.
module grey_step_sequencer
    import grey_step_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n_steps,
    input  logic             hold,
    input  logic             abort,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             adj_err
);

    seq_state_t       state_reg;
    seq_state_t       state_next;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] rem_next;
    logic             done_reg;
    logic             done_next;
    logic             busy_reg;
    logic             cnt_en;
    logic             cnt_clr;

    logic [WIDTH-1:0] q_last_reg;
    logic             skip_reg;
    logic             adj_err_reg;
    logic [WIDTH-1:0] q_diff;

    gray_cnt_en #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .q   (q)
    );

    // Next-state, step enable and done decode; abort outranks hold and the last step.
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        done_next  = 1'b0;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // clear is applied on the same edge a run is accepted, so the run starts at 0
                if (clr) begin
                    cnt_clr = 1'b1;
                end
                if (start) begin
                    if (n_steps != '0) begin
                        state_next = ST_RUN;
                        rem_next   = n_steps;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    rem_next   = '0;
                end else if (hold) begin
                    state_next = ST_PAUSE;
                end else begin
                    cnt_en   = 1'b1;
                    rem_next = rem_reg - WIDTH'(1);
                    if (rem_reg == WIDTH'(1)) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    rem_next   = '0;
                end else if (!hold) begin
                    // resume edge does not step; counting picks up on the following edge
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
                rem_next   = '0;
            end
        endcase
    end

    // FSM, remaining-step counter and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            rem_reg   <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            done_reg  <= done_next;
            busy_reg  <= (state_next != ST_IDLE);
        end
    end

    // Per-bit difference between the current and previous q.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_diff
        assign q_diff[gi] = q[gi] ^ q_last_reg[gi];
    end

    // Adjacency checker: looks at each q change one cycle after it lands;
    // the jump caused by a clear is skipped because it is not a step.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_last_reg  <= '0;
            skip_reg    <= 1'b1;
            adj_err_reg <= 1'b0;
        end else begin
            q_last_reg <= q;
            skip_reg   <= cnt_clr;
            if (!skip_reg && (q_diff != '0) && (popcount(32'(q_diff)) != 1)) begin
                adj_err_reg <= 1'b1;
            end
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign adj_err = adj_err_reg;

endmodule

// File: tb/tb_grey_step_sequencer.sv
// Scoreboard bench for grey_step_sequencer: expected q codes are queued as runs
// are driven and popped by a monitor each time q changes.
module tb_grey_step_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] n_steps;
    logic       hold;
    logic       abort;
    logic       clr;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       adj_err;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int model_b  = 0;
    bit mon_en   = 1'b0;
    logic [3:0] q_last = 4'd0;
    logic [3:0] exp_q[$];

    grey_step_sequencer #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .n_steps (n_steps),
        .hold    (hold),
        .abort   (abort),
        .clr     (clr),
        .q       (q),
        .busy    (busy),
        .done    (done),
        .adj_err (adj_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            $display("ok   %s: %0d", tag, act);
        end
    endtask

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] bb;
        bb = 4'(b);
        return bb ^ (bb >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance the bench's binary model by one step and queue the resulting code.
    task automatic push_step();
        model_b = (model_b + 1) % 16;
        exp_q.push_back(gray4(model_b));
    endtask

    // Queue the jump to zero caused by clear or reset (only visible if q moves).
    task automatic push_zero();
        if (model_b != 0) exp_q.push_back(4'd0);
        model_b = 0;
    endtask

    // One run: hold for hold_len edges after step hold_at, abort after step abort_at,
    // reset on edge rst_at, optional clr with start, optional start/clr poke while busy.
    task automatic do_run(input int n, input int hold_at, input int hold_len,
                          input int abort_at, input int rst_at, input bit cws,
                          input bit poke);
        int steps;
        int exp_edge;
        bit stop_ev;
        if (cws) push_zero();
        steps = n;
        if (abort_at != 0) steps = abort_at;
        if (rst_at != 0) steps = rst_at - 1;
        for (int i = 0; i < steps; i++) push_step();
        if (rst_at != 0) push_zero();
        exp_edge = n + ((hold_len > 0) ? hold_len + 1 : 0);
        if (abort_at == 0 && rst_at == 0) exp_done++;

        start = 1'b1; n_steps = 4'(n); clr = cws;
        tick();
        start = 1'b0; clr = 1'b0;
        if (n == 0) begin
            check("zero_done", int'(done), 1);
            check("zero_busy", int'(busy), 0);
            check("zero_q", int'(q), int'(gray4(model_b)));
            return;
        end
        check("busy_after_start", int'(busy), 1);
        for (int j = 1; j <= 40; j++) begin
            hold  = (hold_len > 0) && (j > hold_at) && (j <= hold_at + hold_len);
            abort = (abort_at != 0) && (j == abort_at + 1);
            rst   = (rst_at != 0) && (j == rst_at);
            stop_ev = abort || rst;
            if (poke && j == 2) begin
                start = 1'b1; n_steps = 4'd2; clr = 1'b1;
            end
            tick();
            start = 1'b0; clr = 1'b0; hold = 1'b0; abort = 1'b0; rst = 1'b0;
            if (stop_ev) begin
                check("stop_busy", int'(busy), 0);
                check("stop_done", int'(done), 0);
                check("stop_q", int'(q), int'(gray4(model_b)));
                return;
            end
            if (done) begin
                check("done_edge", j, exp_edge);
                check("done_q", int'(q), int'(gray4(model_b)));
                check("done_busy", int'(busy), 0);
                return;
            end
            if (j == 40) check("run_timeout", j, exp_edge);
        end
    endtask

    // Monitor: every q change must be the next queued code; count done pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q !== q_last) begin
                if (exp_q.size() == 0) check("q_extra_change", int'(q), int'(q_last));
                else check("q_seq", int'(q), int'(exp_q.pop_front()));
            end
            if (done) done_cnt++;
        end
        q_last = q;
    end

    initial begin
        rst = 1'b1; start = 1'b0; n_steps = 4'd0; hold = 1'b0; abort = 1'b0; clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_q", int'(q), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_adj_err", int'(adj_err), 0);
        mon_en = 1'b1;
        tick();

        do_run(3, 0, 0, 0, 0, 1'b0, 1'b0);     // 0001,0011,0010
        tick();
        do_run(13, 0, 0, 0, 0, 1'b0, 1'b0);    // through 1000, wraps to 0000
        check("wrap_q", int'(q), 0);
        tick();
        do_run(5, 2, 2, 0, 0, 1'b0, 1'b0);     // hold two edges after step 2
        tick();
        do_run(8, 0, 0, 3, 0, 1'b0, 1'b0);     // abort after step 3
        tick(); tick();
        check("abort_no_done", done_cnt, exp_done);
        do_run(2, 0, 0, 0, 0, 1'b1, 1'b0);     // clr with start: restart from 0
        tick();
        do_run(0, 0, 0, 0, 0, 1'b0, 1'b0);     // zero steps: done only
        tick();
        do_run(8, 0, 0, 0, 3, 1'b0, 1'b0);     // reset on edge 3 of the run
        check("midrst_q", int'(q), 0);
        tick();
        do_run(4, 0, 0, 0, 0, 1'b0, 1'b1);     // start/clr while busy ignored

        tick(); tick(); tick();
        check("queue_empty", exp_q.size(), 0);
        check("done_count", done_cnt, exp_done);
        check("final_q", int'(q), int'(gray4(model_b)));
        check("final_adj_err", int'(adj_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
